// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding and
// the default watchdog limit.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    D_ACCESS = 2'd1,
    I_ACCESS = 2'd2
  } state_t;

  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/arb_watchdog.sv
// Access watchdog: counts access cycles spent waiting on mem_ready and flags
// expiry in the cycle that would make the wait reach TIMEOUT.
module arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] count;

  // Wait-cycle counter, zeroed whenever no access is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign expire = enable & (count == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and the
// MEM-stage data access; data always wins, every access is watchdog-guarded.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        bus_err,
  output logic [31:0] conflict_cnt
);

  state_t      state;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;
  logic        lat_we;
  logic        in_access;
  logic        data_req;
  logic        expire;
  logic        complete;
  logic        conflict_hit;

  assign data_req  = d_read | d_write;
  assign in_access = (state == D_ACCESS) | (state == I_ACCESS);
  assign complete  = in_access & (mem_ready | expire);

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == IDLE),
    .enable (in_access & ~mem_ready),
    .expire (expire)
  );

  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign mem_be    = lat_be;
  assign mem_we    = lat_we;

  // Completion pulses; an aborted access returns zero data.
  always_comb begin
    if_done  = 1'b0;
    if_rdata = 32'h0;
    d_done   = 1'b0;
    d_rdata  = 32'h0;
    case (state)
      D_ACCESS: begin
        d_done  = complete;
        d_rdata = (complete & mem_ready) ? mem_rdata : 32'h0;
      end
      I_ACCESS: begin
        if_done  = complete;
        if_rdata = (complete & mem_ready) ? mem_rdata : 32'h0;
      end
      default: begin
        if_done = 1'b0;
      end
    endcase
  end

  assign stall_mem = data_req & ~d_done;
  assign stall_if  = (if_req & ~if_done) | stall_mem;

  // Arbitration FSM; request fields are captured on entry and held until completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
      lat_be    <= 4'h0;
      lat_we    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (data_req) begin
            state     <= D_ACCESS;
            mem_req   <= 1'b1;
            lat_addr  <= d_addr;
            lat_wdata <= d_wdata;
            lat_be    <= d_be;
            lat_we    <= d_write;
          end else if (if_req) begin
            state     <= I_ACCESS;
            mem_req   <= 1'b1;
            lat_addr  <= if_addr;
            lat_wdata <= 32'h0;
            lat_be    <= 4'b1111;
            lat_we    <= 1'b0;
          end
        end
        D_ACCESS, I_ACCESS: begin
          if (complete) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            lat_we  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          lat_we  <= 1'b0;
        end
      endcase
    end
  end

  assign conflict_hit = if_req & ~if_done &
                        ((state == D_ACCESS) | ((state == IDLE) & data_req));

  // Sticky timeout flag and lost-fetch-cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_err      <= 1'b0;
      conflict_cnt <= 32'h0;
    end else begin
      if (expire) begin
        bus_err <= 1'b1;
      end
      if (conflict_hit) begin
        conflict_cnt <= conflict_cnt + 32'd1;
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning max wait cycles for mem_ready before an access is aborted (range 1..255).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 if_req  in  1  instruction fetch request (level, held until if_done).
REQ-005 if_addr  in  32  fetch address.
REQ-006 if_done  out  1  one-cycle pulse: fetch complete, if_rdata valid this cycle.
REQ-007 if_rdata  out  32  fetch data.
REQ-008 d_read / d_write  in  1 each  MEM-stage load / store request (level; never both high).
REQ-009 d_addr  in  32; d_wdata  in  32; d_be  in  4  data access address, store data, byte enables.
REQ-010 d_done  out  1  one-cycle pulse: data access complete, d_rdata valid this cycle.
REQ-011 d_rdata  out  32  load data.
REQ-012 stall_if  out  1  fetch stage must hold; stall_mem  out  1  pipeline must freeze for MEM access.
REQ-013 mem_req  out  1; mem_we  out  1; mem_addr  out  32; mem_wdata  out  32; mem_be  out  4  single shared memory port.
REQ-014 mem_ready  in  1; mem_rdata  in  32  memory completion and read data.
REQ-015 bus_err  out  1  sticky timeout flag; conflict_cnt  out  32  count of fetch cycles lost to data priority.

Function
REQ-016 FSM states IDLE, D_ACCESS, I_ACCESS; encoding from shared package.
REQ-017 IDLE: d_read|d_write -> D_ACCESS; else if_req -> I_ACCESS; else stay. Data always wins simultaneous requests.
REQ-018 Entering an access state latches address, we, wdata, be into registers; mem_* outputs driven only from these registers.
REQ-019 mem_req SHALL be high in exactly D_ACCESS and I_ACCESS; request fields stable until completion.
REQ-020 mem_we = 1 only for d_write accesses; fetch uses mem_be = 4'b1111, mem_we = 0.
REQ-021 Completion: mem_ready high in an access state -> matching done pulses same cycle (combinational), rdata = mem_rdata, next state IDLE.
REQ-022 Min latency: request seen in IDLE at cycle N, mem_req at N+1, done earliest N+1 if mem_ready already high.
REQ-023 No re-issue in the done cycle: IDLE always inserts one arbitration cycle between accesses.
REQ-024 stall_mem = (d_read|d_write) & ~d_done; stall_if = if_req & ~if_done | stall_mem.
REQ-025 Request withdrawn mid-access (flush): transaction runs to completion, done still pulses, requester discards it.
REQ-026 Watchdog: 8-bit counter clears on access entry, increments each access cycle without mem_ready; reaching TIMEOUT -> abort: done pulses, rdata = 0, bus_err set, state IDLE.
REQ-027 bus_err cleared only by reset.
REQ-028 conflict_cnt increments each cycle if_req high, if_done low and state is D_ACCESS or a data request wins in IDLE; wraps at 2^32-1 to 0.
REQ-029 if_rdata / d_rdata = 0 when their done is low.

Reset
REQ-030 reset asserted -> immediately: state IDLE, mem_req 0, mem_we 0, latched fields 0, watchdog 0, bus_err 0, conflict_cnt 0.
REQ-031 Reset mid-access abandons the transaction; no done pulse is produced.

Structure
REQ-032 Package mem_arb_pkg holds state typedef and TIMEOUT default.
REQ-033 Watchdog counter is one sub-module, arb_watchdog (clear, enable, expire out).

Verification
REQ-034 d_read and if_req raised together, mem_ready 2 cycles later each -> data access first (mem_we 0), d_done, one IDLE cycle, fetch, if_done; conflict_cnt = 3.
REQ-035 d_write addr 0x100, wdata 0xDEADBEEF, be 4'b0011, mem_ready held high -> mem_req at N+1 with those values, d_done at N+1, stall_mem low at N+1.
REQ-036 if_req only, mem_ready never high, TIMEOUT 4 -> if_done after 4 access cycles, if_rdata 0, bus_err 1 and stays 1.
REQ-037 reset pulsed in I_ACCESS cycle 2 -> mem_req 0 same cycle, no if_done, all counters 0.
REQ-038 d_read dropped during D_ACCESS -> mem_req held, d_done still pulses on mem_ready, then IDLE.
